// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared master indices, default starvation limit and RAM address window
package dmem_arb_pkg;
  localparam int MST_CPU = 0;
  localparam int MST_DMA = 1;
  localparam int STARVE_LIMIT_DEFAULT = 4;
  localparam int RAM_ADDR_LSB = 2;
  localparam int RAM_ADDR_MSB = 9;
endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: saturating denial counter for the DMA master
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : M1 requested and was denied this cycle (saturates at LIMIT)
//   clr        : M1 granted or idle; counter returns to 0
//   at_limit   : counter has reached LIMIT, M1 must win the next contention
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign at_limit = cnt_q == CNT_W'(LIMIT);
  always_comb cnt_d = clr ? '0 : (inc & ~at_limit) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter (CPU fixed priority, DMA starvation escape) for a single-port data memory
//   m0_* : CPU MEM-stage port (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   m1_* : DMA/UART loader port, same shape as m0_*
//   cpu_stall : CPU requested but was not granted this cycle
//   mem_* : DataMemory drive (addr/wdata/rd/wr out, rdata in, async read)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);
  logic [1:0] gnt;
  logic at_limit, starve_inc;
  logic m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  // rst_n gates the grants so no memory access can start while reset is held
  assign gnt[MST_DMA] = rst_n & m1_req & (~m0_req | at_limit);
  assign gnt[MST_CPU] = rst_n & m0_req & ~gnt[MST_DMA];
  assign m0_gnt = gnt[MST_CPU];
  assign m1_gnt = gnt[MST_DMA];
  assign cpu_stall = m0_req & ~m0_gnt;
  assign starve_inc = m1_req & ~m1_gnt;
  dmem_arb_starve_ctr #(.LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_starve (
    .clk(clk),
    .rst_n(rst_n),
    .inc(starve_inc),
    .clr(~starve_inc),
    .at_limit(at_limit)
  );
  always_comb begin
    mem_addr = gnt[MST_CPU] ? m0_addr : gnt[MST_DMA] ? m1_addr : '0;
    mem_wdata = gnt[MST_CPU] ? m0_wdata : gnt[MST_DMA] ? m1_wdata : '0;
    mem_rd = (gnt[MST_CPU] & ~m0_we) | (gnt[MST_DMA] & ~m1_we);
    mem_wr = (gnt[MST_CPU] & m0_we) | (gnt[MST_DMA] & m1_we);
    m0_rvalid_d = gnt[MST_CPU] & ~m0_we;
    m1_rvalid_d = gnt[MST_DMA] & ~m1_we;
    m0_rdata_d = m0_rvalid_d ? mem_rdata : m0_rdata_q;
    m1_rdata_d = m1_rvalid_d ? mem_rdata : m1_rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random and directed checks of dmem_arbiter against a behavioural arbitration/memory model
module tb_dmem_arbiter;
  localparam int LIM = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, cpu_stall, mem_rd, mem_wr;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] tb_mem [256] = '{default: 32'h0};
  logic [31:0] ref_mem [256] = '{default: 32'h0};
  int n_chk = 0, n_fail = 0, den = 0;
  logic g0 = 0, g1 = 0, og0 = 0, og1 = 0, rv0 = 0, rv1 = 0;
  logic [31:0] rd0 = 0, rd1 = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_wr) tb_mem[mem_addr[9:2]] <= mem_wdata;
  assign mem_rdata = tb_mem[mem_addr[9:2]];
  dmem_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .cpu_stall(cpu_stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic set0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
  endtask
  task automatic set1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
  endtask
  // one clock: check combinational outputs mid-cycle, advance the model at the edge, check registered outputs
  task automatic cyc();
    logic e0, e1;
    @(negedge clk);
    e1 = m1_req && (!m0_req || den == LIM);
    e0 = m0_req && !e1;
    og0 = m0_gnt; og1 = m1_gnt;
    check("m0_gnt", {31'b0, m0_gnt}, {31'b0, e0});
    check("m1_gnt", {31'b0, m1_gnt}, {31'b0, e1});
    check("cpu_stall", {31'b0, cpu_stall}, {31'b0, m0_req && !e0});
    check("mem_addr", mem_addr, e0 ? m0_addr : e1 ? m1_addr : 32'h0);
    check("mem_wdata", mem_wdata, e0 ? m0_wdata : e1 ? m1_wdata : 32'h0);
    check("mem_rd", {31'b0, mem_rd}, {31'b0, (e0 && !m0_we) || (e1 && !m1_we)});
    check("mem_wr", {31'b0, mem_wr}, {31'b0, (e0 && m0_we) || (e1 && m1_we)});
    @(posedge clk);
    #1;
    rv0 = e0 && !m0_we;
    rv1 = e1 && !m1_we;
    if (rv0) rd0 = ref_mem[m0_addr[9:2]];
    if (rv1) rd1 = ref_mem[m1_addr[9:2]];
    if (e0 && m0_we) ref_mem[m0_addr[9:2]] = m0_wdata;
    if (e1 && m1_we) ref_mem[m1_addr[9:2]] = m1_wdata;
    den = (m1_req && !e1) ? ((den < LIM) ? den + 1 : den) : 0;
    g0 = e0; g1 = e1;
    check("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, rv0});
    check("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, rv1});
    check("m0_rdata", m0_rdata, rd0);
    check("m1_rdata", m1_rdata, rd1);
  endtask
  // asynchronous reset asserted mid-cycle, held across one edge, released away from the edge
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_m0_gnt", {31'b0, m0_gnt}, 32'h0);
    check("rst_m1_gnt", {31'b0, m1_gnt}, 32'h0);
    check("rst_mem_rd", {31'b0, mem_rd}, 32'h0);
    check("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_m0_rdata", m0_rdata, 32'h0);
    check("rst_m1_rdata", m1_rdata, 32'h0);
    den = 0; g0 = 0; g1 = 0; rv0 = 0; rv1 = 0; rd0 = 0; rd1 = 0;
    @(posedge clk);
    #1;
    check("rst_m0_rvalid", {31'b0, m0_rvalid}, 32'h0);
    check("rst_m1_rvalid", {31'b0, m1_rvalid}, 32'h0);
    rst_n = 1'b1;
  endtask
  initial begin
    logic act0, act1;
    logic [31:0] a;
    int wait_n;
    act0 = 0; act1 = 0;
    #3;
    check("init_gnt", {30'b0, m1_gnt, m0_gnt}, 32'h0);
    check("init_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
    check("init_rdata", m0_rdata | m1_rdata, 32'h0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    set0(1, 1, 32'h10, 32'hDEADBEEF);
    cyc();
    check("t1_wr_gnt", {31'b0, og0}, 32'h1);
    set0(1, 0, 32'h10, 32'h0);
    cyc();
    check("t1_rd_gnt", {31'b0, og0}, 32'h1);
    check("t1_rdata", m0_rdata, 32'hDEADBEEF);
    check("t1_rvalid", {31'b0, m0_rvalid}, 32'h1);
    set0(0, 0, 0, 0);
    cyc();
    check("t1_rvalid_drop", {31'b0, m0_rvalid}, 32'h0);
    set1(1, 0, 32'h40, 32'h0);
    cyc();
    check("t2_rvalid", {31'b0, m1_rvalid}, 32'h1);
    check("t2_rdata", m1_rdata, 32'h0);
    set1(0, 0, 0, 0);
    cyc();
    check("t2_rvalid_once", {31'b0, m1_rvalid}, 32'h0);
    set0(1, 0, 32'h100, 32'h0);
    set1(1, 0, 32'h104, 32'h0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("t3_pattern", {31'b0, og1}, {31'b0, i % 5 == 4});
    end
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    cyc();
    set0(1, 1, 32'h20, 32'h1111);
    set1(1, 1, 32'h20, 32'h2222);
    cyc();
    check("t4_m0_first", {30'b0, og1, og0}, 32'h1);
    set0(0, 0, 0, 0);
    cyc();
    check("t4_m1_next", {30'b0, og1, og0}, 32'h2);
    set1(0, 0, 0, 0);
    set0(1, 0, 32'h20, 32'h0);
    cyc();
    check("t4_readback", m0_rdata, 32'h2222);
    set0(1, 0, 32'h10, 32'h0);
    #1 check("t5_gnt_before_rst", {31'b0, m0_gnt}, 32'h1);
    do_reset();
    set0(0, 0, 0, 0);
    cyc();
    check("t5_no_rvalid", {31'b0, m0_rvalid}, 32'h0);
    set0(1, 0, 32'h80, 32'h0);
    set1(1, 0, 32'h84, 32'h0);
    cyc(); cyc();
    set1(0, 0, 0, 0);
    cyc();
    check("t6_m0_unaffected", {31'b0, og0}, 32'h1);
    set1(1, 1, 32'h88, 32'h5555);
    wait_n = 0;
    for (int i = 0; i < 10 && !g1; i++) begin
      cyc();
      wait_n++;
    end
    check("t6_wait", wait_n, LIM + 1);
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    cyc();
    act0 = 0; act1 = 0;
    for (int it = 0; it < 600; it++) begin
      if (!act0 || g0) begin
        act0 = $urandom_range(0, 3) != 0;
        a = $urandom; a[9:2] = 8'($urandom_range(0, 7));
        set0(act0, 1'($urandom), a, $urandom);
      end
      if (!act1 || g1) begin
        act1 = $urandom_range(0, 2) != 0;
        a = $urandom; a[9:2] = 8'($urandom_range(0, 7));
        set1(act1, 1'($urandom), a, $urandom);
      end else if ($urandom_range(0, 9) == 0) begin
        act1 = 0;
        m1_req = 0;
      end
      if (it == 300) do_reset();
      else cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
